// File: rtl/data_mem_mmio_if.sv
// rtl/data_mem_mmio_if.sv - core-side data memory bus (store strobe, address, store data, load data)
interface data_mem_mmio_if;
  logic        MemWrite;
  logic [31:0] ALUOut;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, output ALUOut, output WriteData, input ReadData);
  modport slave  (input MemWrite, input ALUOut, input WriteData, output ReadData);
endinterface

// File: rtl/data_mem_mmio.sv
// rtl/data_mem_mmio.sv - word RAM plus GPIO/timer MMIO window; timer built only with DATA_MEM_TIMER_EN
module data_mem_mmio #(
  parameter int          ADDR_W    = 10,
  parameter logic [23:0] MMIO_BASE = 24'hFFFFFF,
  parameter logic [31:0] CMP_RESET = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_mmio_if.slave    bus,
  output logic [31:0]       gpio_out,
  output logic              timer_irq
);

  logic              mmio_sel;
  logic [7:0]        offset;
  logic [ADDR_W-1:0] idx;
  logic              mmio_wr;
  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic [31:0]       rdata;

  assign mmio_sel = (bus.ALUOut[31:8] == MMIO_BASE);
  assign offset   = bus.ALUOut[7:0];
  assign idx      = bus.ALUOut[ADDR_W+1:2];
  assign mmio_wr  = bus.MemWrite && mmio_sel;

  // RAM store port; no reset on contents, and a store seen while reset is held is dropped
  always_ff @(posedge clk) begin
    if (bus.MemWrite && !mmio_sel && !reset)
      ram[idx] <= bus.WriteData;
  end

  // GPIO output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      gpio_out <= '0;
    else if (mmio_wr && offset == 8'h00)
      gpio_out <= bus.WriteData;
  end

`ifdef DATA_MEM_TIMER_EN
  logic [31:0] count;
  logic [31:0] cmp;
  logic [1:0]  ctrl;
  logic        match;
  logic        hit;

  // compare uses the register values before any store in this cycle lands
  assign hit = ctrl[0] && (count == cmp);

  // timer: CPU store to COUNT beats increment/reload; MATCH set beats W1C clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      cmp       <= CMP_RESET;
      ctrl      <= '0;
      match     <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      if (mmio_wr && offset == 8'h08)
        cmp <= bus.WriteData;
      if (mmio_wr && offset == 8'h0C)
        ctrl <= bus.WriteData[1:0];
      if (mmio_wr && offset == 8'h04)
        count <= bus.WriteData;
      else if (ctrl[0])
        count <= (hit && ctrl[1]) ? 32'd0 : count + 32'd1;
      if (hit)
        match <= 1'b1;
      else if (mmio_wr && offset == 8'h10 && bus.WriteData[0])
        match <= 1'b0;
      timer_irq <= match;
    end
  end
`else
  assign timer_irq = 1'b0;
`endif

  // load mux: zero-latency read from RAM or the MMIO registers
  always_comb begin
    rdata = '0;
    if (mmio_sel) begin
      case (offset)
        8'h00:   rdata = gpio_out;
`ifdef DATA_MEM_TIMER_EN
        8'h04:   rdata = count;
        8'h08:   rdata = cmp;
        8'h0C:   rdata = {30'd0, ctrl};
        8'h10:   rdata = {31'd0, match};
`endif
        default: rdata = '0;
      endcase
    end else begin
      rdata = ram[idx];
    end
  end

  assign bus.ReadData = rdata;

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb/tb_data_mem_mmio.sv - scoreboard bench for data_mem_mmio with a reference model of RAM and MMIO
module tb_data_mem_mmio;
  localparam logic [31:0] CMP_RST = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] gpio_out;
  logic        timer_irq;

  data_mem_mmio_if bus();

  data_mem_mmio dut (.clk(clk), .reset(reset), .bus(bus), .gpio_out(gpio_out), .timer_irq(timer_irq));

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_known;
    logic [31:0] rd;
    logic [31:0] gpio;
    logic        irq;
    string       name;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // reference state
  logic [31:0] ram_m [int];
  logic [31:0] m_gpio, m_count, m_cmp;
  logic [1:0]  m_ctrl;
  logic        m_match, m_irq;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic logic is_mmio(input logic [31:0] a);
    return a[31:8] == 24'hFFFFFF;
  endfunction

  function automatic int ram_idx(input logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  task automatic model_reset();
    m_gpio = 0; m_count = 0; m_cmp = CMP_RST; m_ctrl = 0; m_match = 0; m_irq = 0;
  endtask

  task automatic model_read(input logic [31:0] a, output logic known, output logic [31:0] rd);
    known = 1'b1;
    rd = 32'd0;
    if (is_mmio(a)) begin
      if (a[7:0] == 8'h00) rd = m_gpio;
`ifdef DATA_MEM_TIMER_EN
      else if (a[7:0] == 8'h04) rd = m_count;
      else if (a[7:0] == 8'h08) rd = m_cmp;
      else if (a[7:0] == 8'h0C) rd = {30'd0, m_ctrl};
      else if (a[7:0] == 8'h10) rd = {31'd0, m_match};
`endif
    end else begin
      known = ram_m.exists(ram_idx(a));
      if (known) rd = ram_m[ram_idx(a)];
    end
  endtask

  // advance the model across one rising edge with the given store
  task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic mw;
    logic [7:0] off;
    mw  = we && is_mmio(a);
    off = a[7:0];
    if (we && !is_mmio(a)) ram_m[ram_idx(a)] = wd;
    if (mw && off == 8'h00) m_gpio = wd;
`ifdef DATA_MEM_TIMER_EN
    begin
      logic        matched;
      logic [31:0] nc;
      logic        nm;
      matched = m_ctrl[0] && (m_count == m_cmp);
      nc = m_count;
      if (m_ctrl[0]) nc = (matched && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
      if (mw && off == 8'h04) nc = wd;
      nm = m_match;
      if (mw && off == 8'h10 && wd[0]) nm = 1'b0;
      if (matched) nm = 1'b1;
      m_irq = m_match;
      if (mw && off == 8'h08) m_cmp = wd;
      if (mw && off == 8'h0C) m_ctrl = wd[1:0];
      m_count = nc;
      m_match = nm;
    end
`endif
  endtask

  // one bus cycle: drive, record the expected response, then model the coming edge
  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] wd, input string n);
    exp_t e;
    @(posedge clk);
    #1;
    bus.MemWrite = we; bus.ALUOut = a; bus.WriteData = wd;
    model_read(a, e.rd_known, e.rd);
    e.gpio = m_gpio; e.irq = m_irq; e.name = n;
    q.push_back(e);
    model_edge(we, a, wd);
  endtask

  // monitor: compare DUT outputs against queued expectations mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.rd_known) chk({e.name, "_rd"}, bus.ReadData, e.rd);
        chk({e.name, "_gpio"}, gpio_out, e.gpio);
        chk({e.name, "_irq"}, {31'd0, timer_irq}, {31'd0, e.irq});
      end
    end
  end

  initial begin
    logic [31:0] a, d;
    int w;
    reset = 1'b1;
    bus.MemWrite = 1'b0; bus.ALUOut = 32'd0; bus.WriteData = 32'd0;
    model_reset();
    #12;
    chk("rst_gpio", gpio_out, 32'd0);
    chk("rst_irq", {31'd0, timer_irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    cycle(1, 32'h0000_0010, 32'hDEADBEEF, "ram_st");
    cycle(0, 32'h0000_0010, 0, "ram_ld");
    cycle(0, 32'h0000_1010, 0, "ram_alias");
    cycle(1, 32'h0000_0010, 32'h0BADF00D, "ram_old");
    cycle(0, 32'h0000_0013, 0, "ram_new");
    cycle(1, 32'h0000_0010, 32'hDEADBEEF, "ram_st2");
    cycle(1, 32'hFFFF_FF00, 32'h0000_00A5, "gpio_st");
    cycle(0, 32'hFFFF_FF00, 0, "gpio_ld");
    cycle(1, 32'hFFFF_FF04, 32'h0000_1234, "t04_st");
    cycle(0, 32'hFFFF_FF04, 0, "t04_ld");
    cycle(0, 32'hFFFF_FF20, 0, "unmapped");

    cycle(1, 32'hFFFF_FF08, 5, "os_cmp");
    cycle(1, 32'hFFFF_FF04, 0, "os_cnt");
    cycle(1, 32'hFFFF_FF0C, 1, "os_ctrl");
    repeat (10) cycle(0, 32'hFFFF_FF04, 0, "os_count");
    cycle(0, 32'hFFFF_FF10, 0, "os_stat");
    cycle(1, 32'hFFFF_FF10, 1, "os_w1c");
    cycle(0, 32'hFFFF_FF10, 0, "os_stat2");

    cycle(1, 32'hFFFF_FF08, 3, "ar_cmp");
    cycle(1, 32'hFFFF_FF04, 0, "ar_cnt");
    cycle(1, 32'hFFFF_FF0C, 3, "ar_ctrl");
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 1) cycle(1, 32'hFFFF_FF10, 1, "ar_w1c");
      else cycle(0, (i % 2 == 0) ? 32'hFFFF_FF04 : 32'hFFFF_FF10, 0, "ar_rd");
    end
    cycle(1, 32'hFFFF_FF04, 100, "cnt_ovr");
    cycle(0, 32'hFFFF_FF04, 0, "cnt_ovr_rd");
    cycle(1, 32'hFFFF_FF0C, 0, "ar_off");

    for (int i = 0; i < 400; i++) begin
      w = $urandom_range(0, 9);
      d = $urandom;
      if (w < 5) begin
        a = ($urandom & 32'h7FFF_F003) | (32'($urandom_range(0, 15)) << 2);
      end else begin
        case ($urandom_range(0, 7))
          0: a = 32'hFFFF_FF00;
          1: a = 32'hFFFF_FF04;
          2: a = 32'hFFFF_FF08;
          3: a = 32'hFFFF_FF0C;
          4: a = 32'hFFFF_FF10;
          5: a = 32'hFFFF_FF14;
          default: a = 32'hFFFF_FF00 | ($urandom & 32'hFF);
        endcase
        if (a[7:0] == 8'h08 && d[0]) d = d & 32'h0000_000F;
      end
      cycle(logic'($urandom_range(0, 1)), a, d, "rand");
    end

    cycle(1, 32'hFFFF_FF00, 32'h5A5A_0001, "pre_rst_gpio");
    cycle(1, 32'h0000_0010, 32'hDEADBEEF, "pre_rst_ram");
    @(posedge clk);
    #2;
    reset = 1'b1;
    bus.MemWrite = 1'b1; bus.ALUOut = 32'h0000_0010; bus.WriteData = 32'h1234_5678;
    #1;
    chk("async_rst_gpio", gpio_out, 32'd0);
    chk("async_rst_irq", {31'd0, timer_irq}, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    bus.MemWrite = 1'b0;
    model_reset();
    cycle(0, 32'h0000_0010, 0, "ram_keep");
    cycle(0, 32'hFFFF_FF08, 0, "cmp_rst");
    cycle(0, 32'hFFFF_FF04, 0, "cnt_rst");
    cycle(1, 32'hFFFF_FF04, 0, "irq_cnt");
    cycle(1, 32'hFFFF_FF08, 2, "irq_cmp");
    cycle(1, 32'hFFFF_FF0C, 1, "irq_en");
    repeat (100) cycle(0, 32'hFFFF_FF10, 0, "irq_watch");

    w = 0;
    while (q.size() > 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    #1;
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
